// File: rtl/user_clock_pll_drp_ctrl.sv
// Runtime M/D retune sequencer for the user-clock PLL over its DRP port.
// Optional feature macro: PLL_DRP_READBACK_EN (read back and compare every DRP write).
//
// state     | meaning
// BOOT      | PLL released after reset, waiting for first lock
// IDLE      | ready for a request; CLK_READY follows synced lock
// CHECK     | validate captured M/D
// RST_ON    | PLL held in reset, FB write staged
// WR_FB     | DEN/DWE pulse to CLKFBOUT register
// WAIT_FB   | waiting DRDY for FB write
// RD_FB     | DEN pulse, readback of FB register
// RDW_FB    | waiting DRDY for FB readback
// WR_CO     | DEN/DWE pulse to CLKOUT0 register
// WAIT_CO   | waiting DRDY for CO write
// RD_CO     | DEN pulse, readback of CO register
// RDW_CO    | waiting DRDY for CO readback
// RST_OFF   | PLL reset released
// WAIT_LOCK | waiting synced lock

module user_clock_pll_drp_ctrl #(
   parameter logic [4:0]  ADDR_CLKOUT0 = 5'h08,
   parameter logic [4:0]  ADDR_CLKFB   = 5'h14,
   parameter int unsigned DRDY_TIMEOUT = 64,
   parameter int unsigned LOCK_TIMEOUT = 65535
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [5:0]  i_req_mult,
   input  logic [5:0]  i_req_div,
   output logic        o_pll_rst,
   input  logic        i_pll_locked,
   output logic [4:0]  o_drp_daddr,
   output logic [15:0] o_drp_di,
   output logic        o_drp_den,
   output logic        o_drp_dwe,
   input  logic [15:0] i_drp_do,
   input  logic        i_drp_drdy,
   output logic        o_clk_ready,
   output logic        o_done,
   output logic        o_err
);

   // DRDY timer is loaded one cycle after DEN, so ERR lands DRDY_TIMEOUT cycles after DEN
   localparam logic [15:0] C_DRDY_LOAD = 16'(DRDY_TIMEOUT - 2);
   localparam logic [15:0] C_LOCK_LOAD = 16'(LOCK_TIMEOUT);

   typedef enum logic [3:0] {
      S_BOOT, S_IDLE, S_CHECK, S_RST_ON,
      S_WR_FB, S_WAIT_FB, S_RD_FB, S_RDW_FB,
      S_WR_CO, S_WAIT_CO, S_RD_CO, S_RDW_CO,
      S_RST_OFF, S_WAIT_LOCK
   } state_t;

   state_t      r_state;
   logic        r_req_ready;
   logic        r_pll_rst;
   logic [4:0]  r_daddr;
   logic [15:0] r_di;
   logic        r_den;
   logic        r_dwe;
   logic        r_done;
   logic        r_err;
   logic [15:0] r_timer;
   logic        r_failed;
   logic [5:0]  r_mult;
   logic [5:0]  r_div;
   logic        r_lock_meta;
   logic        r_lock_sync;
   logic        w_req_ok;

   function automatic logic [15:0] f_enc(input logic [5:0] n);
      logic [5:0] hi;
      logic [5:0] lo;
      hi = n >> 1;
      lo = n - hi;
      return {2'b00, hi, (n == 6'd1), n[0], lo};
   endfunction

   assign w_req_ok = (r_mult >= 6'd1) && (r_mult <= 6'd32) &&
                     (r_div >= 6'd2) && (r_div <= 6'd32);

`ifndef PLL_DRP_READBACK_EN
   logic w_unused_drp_do;
   assign w_unused_drp_do = ^i_drp_do;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_BOOT;
         r_req_ready <= 1'b0;
         r_pll_rst   <= 1'b1;
         r_daddr     <= '0;
         r_di        <= '0;
         r_den       <= 1'b0;
         r_dwe       <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_timer     <= C_LOCK_LOAD;
         r_failed    <= 1'b0;
         r_mult      <= '0;
         r_div       <= '0;
         r_lock_meta <= 1'b0;
         r_lock_sync <= 1'b0;
      end else begin
         r_lock_meta <= i_pll_locked;
         r_lock_sync <= r_lock_meta;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_den       <= 1'b0;
         r_dwe       <= 1'b0;

         case (r_state)
            S_BOOT: begin
               r_pll_rst <= 1'b0;
               if (r_lock_sync) begin
                  r_state     <= S_IDLE;
                  r_req_ready <= 1'b1;
               end else if (r_timer == 16'd0) begin
                  r_err       <= 1'b1;
                  r_state     <= S_IDLE;
                  r_req_ready <= 1'b1;
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end

            S_IDLE: begin
               if (i_req_valid && r_req_ready) begin
                  r_mult      <= i_req_mult;
                  r_div       <= i_req_div;
                  r_req_ready <= 1'b0;
                  r_state     <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (!w_req_ok) begin
                  r_err       <= 1'b1;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_pll_rst <= 1'b1;
                  r_failed  <= 1'b0;
                  r_state   <= S_RST_ON;
               end
            end

            S_RST_ON: begin
               r_daddr <= ADDR_CLKFB;
               r_di    <= f_enc(r_mult);
               r_den   <= 1'b1;
               r_dwe   <= 1'b1;
               r_state <= S_WR_FB;
            end

            S_WR_FB: begin
               r_timer <= C_DRDY_LOAD;
               r_state <= S_WAIT_FB;
            end

            S_WAIT_FB: begin
               if (i_drp_drdy) begin
`ifdef PLL_DRP_READBACK_EN
                  r_den   <= 1'b1;
                  r_state <= S_RD_FB;
`else
                  r_daddr <= ADDR_CLKOUT0;
                  r_di    <= f_enc(r_div);
                  r_den   <= 1'b1;
                  r_dwe   <= 1'b1;
                  r_state <= S_WR_CO;
`endif
               end else if (r_timer == 16'd0) begin
                  r_err     <= 1'b1;
                  r_failed  <= 1'b1;
                  r_pll_rst <= 1'b0;
                  r_state   <= S_RST_OFF;
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end

`ifdef PLL_DRP_READBACK_EN
            S_RD_FB: begin
               r_timer <= C_DRDY_LOAD;
               r_state <= S_RDW_FB;
            end

            S_RDW_FB: begin
               if (i_drp_drdy && (i_drp_do == r_di)) begin
                  r_daddr <= ADDR_CLKOUT0;
                  r_di    <= f_enc(r_div);
                  r_den   <= 1'b1;
                  r_dwe   <= 1'b1;
                  r_state <= S_WR_CO;
               end else if (i_drp_drdy || (r_timer == 16'd0)) begin
                  r_err     <= 1'b1;
                  r_failed  <= 1'b1;
                  r_pll_rst <= 1'b0;
                  r_state   <= S_RST_OFF;
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end
`endif

            S_WR_CO: begin
               r_timer <= C_DRDY_LOAD;
               r_state <= S_WAIT_CO;
            end

            S_WAIT_CO: begin
               if (i_drp_drdy) begin
`ifdef PLL_DRP_READBACK_EN
                  r_den   <= 1'b1;
                  r_state <= S_RD_CO;
`else
                  r_pll_rst <= 1'b0;
                  r_state   <= S_RST_OFF;
`endif
               end else if (r_timer == 16'd0) begin
                  r_err     <= 1'b1;
                  r_failed  <= 1'b1;
                  r_pll_rst <= 1'b0;
                  r_state   <= S_RST_OFF;
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end

`ifdef PLL_DRP_READBACK_EN
            S_RD_CO: begin
               r_timer <= C_DRDY_LOAD;
               r_state <= S_RDW_CO;
            end

            S_RDW_CO: begin
               if (i_drp_drdy && (i_drp_do == r_di)) begin
                  r_pll_rst <= 1'b0;
                  r_state   <= S_RST_OFF;
               end else if (i_drp_drdy || (r_timer == 16'd0)) begin
                  r_err     <= 1'b1;
                  r_failed  <= 1'b1;
                  r_pll_rst <= 1'b0;
                  r_state   <= S_RST_OFF;
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end
`endif

            S_RST_OFF: begin
               r_timer <= C_LOCK_LOAD;
               r_state <= S_WAIT_LOCK;
            end

            // After a DRP failure the ERR was already issued; only wait out the relock
            S_WAIT_LOCK: begin
               if (r_lock_sync) begin
                  r_done      <= !r_failed;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end else if (r_timer == 16'd0) begin
                  r_err       <= !r_failed;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end

            default: begin
               r_pll_rst   <= 1'b0;
               r_req_ready <= 1'b0;
               r_timer     <= C_LOCK_LOAD;
               r_state     <= S_BOOT;
            end
         endcase
      end
   end

   assign o_req_ready = r_req_ready;
   assign o_pll_rst   = r_pll_rst;
   assign o_drp_daddr = r_daddr;
   assign o_drp_di    = r_di;
   assign o_drp_den   = r_den;
   assign o_drp_dwe   = r_dwe;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_clk_ready = (r_state == S_IDLE) && r_lock_sync;

endmodule

// File: tb/tb_user_clock_pll_drp_ctrl.sv
// Bench for user_clock_pll_drp_ctrl: PLL/DRP behavioural models plus write and DONE/ERR scoreboards.
module tb_user_clock_pll_drp_ctrl;
   localparam int LOCK_TO  = 300;
   localparam int DRDY_TO  = 64;
   localparam int LOCK_DLY = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [5:0]  req_mult = '0;
   logic [5:0]  req_div = '0;
   logic        req_ready;
   logic        pll_rst;
   logic        pll_locked = 1'b0;
   logic [4:0]  daddr;
   logic [15:0] di;
   logic        den;
   logic        dwe;
   logic [15:0] drp_do = '0;
   logic        drp_drdy = 1'b0;
   logic        clk_ready;
   logic        done;
   logic        err;

   user_clock_pll_drp_ctrl #(
      .ADDR_CLKOUT0 (5'h08),
      .ADDR_CLKFB   (5'h14),
      .DRDY_TIMEOUT (DRDY_TO),
      .LOCK_TIMEOUT (LOCK_TO)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_mult   (req_mult),
      .i_req_div    (req_div),
      .o_pll_rst    (pll_rst),
      .i_pll_locked (pll_locked),
      .o_drp_daddr  (daddr),
      .o_drp_di     (di),
      .o_drp_den    (den),
      .o_drp_dwe    (dwe),
      .i_drp_do     (drp_do),
      .i_drp_drdy   (drp_drdy),
      .o_clk_ready  (clk_ready),
      .o_done       (done),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;
   int n_done = 0;
   int n_err = 0;
   int n_den = 0;
   bit lock_en = 1'b0;
   bit drdy_en = 1'b1;
   bit rb_corrupt = 1'b0;
   int drp_lat = 1;
   int lock_cnt = 0;
   int drdy_cnt = 0;
   logic [15:0] drp_mem [0:31];

   typedef struct packed {logic [4:0] addr; logic [15:0] data;} wr_t;
   wr_t exp_wr_q[$];
   bit  exp_ev_q[$];
   wr_t w_exp;
   bit  ev_exp;

   function automatic logic [15:0] exp_di(input int n);
      int hi;
      int lo;
      hi = n / 2;
      lo = n - hi;
      return 16'((hi << 8) | ((n == 1) ? 128 : 0) | ((n % 2) * 64) | lo);
   endfunction

   // PLL lock, DRP responder and output scoreboards, evaluated 2ns after each rising edge
   always @(posedge clk) begin
      #2;
      if (pll_rst || !lock_en) begin
         pll_locked = 1'b0;
         lock_cnt = 0;
      end else if (lock_cnt >= LOCK_DLY) begin
         pll_locked = 1'b1;
      end else begin
         lock_cnt++;
      end

      drp_drdy = 1'b0;
      if (drdy_cnt > 0) begin
         drdy_cnt--;
         if (drdy_cnt == 0) drp_drdy = 1'b1;
      end
      if (den) begin
         n_den++;
         if (dwe) begin
            n_checks++;
            if (exp_wr_q.size() == 0) begin
               $display("FAIL drp_write: unexpected write addr=%h di=%h", daddr, di);
            end else begin
               w_exp = exp_wr_q.pop_front();
               if ({daddr, di} !== w_exp)
                  $display("FAIL drp_write: got addr=%h di=%h, expected addr=%h di=%h",
                           daddr, di, w_exp.addr, w_exp.data);
               else n_pass++;
            end
            n_checks++;
            if (pll_rst !== 1'b1) $display("FAIL pll_rst_during_write: got %b, expected 1", pll_rst);
            else n_pass++;
            drp_mem[daddr] = di;
         end else begin
            drp_do = drp_mem[daddr] ^ (rb_corrupt ? 16'h0100 : 16'h0000);
         end
         if (drdy_en) drdy_cnt = drp_lat;
      end

      if (done || err) begin
         if (done) n_done++;
         if (err) n_err++;
         n_checks++;
         if (exp_ev_q.size() == 0) begin
            $display("FAIL event: unexpected done=%b err=%b", done, err);
         end else begin
            ev_exp = exp_ev_q.pop_front();
            if ({done, err} !== {ev_exp, !ev_exp})
               $display("FAIL event: got done=%b err=%b, expected done=%b err=%b",
                        done, err, ev_exp, !ev_exp);
            else n_pass++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_req(input logic [5:0] m, input logic [5:0] d, output bit to);
      to = 1'b1;
      req_mult = m;
      req_div = d;
      req_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (req_ready === 1'b1) begin
            @(posedge clk);
            #1;
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_event(input int budget, output bit got_done, output bit got_err, output bit to);
      got_done = 1'b0;
      got_err = 1'b0;
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done || err) begin
            got_done = done;
            got_err = err;
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_ready(input int budget, output bit to);
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (clk_ready && req_ready) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      bit to;
      lock_en = 1'b0;
      rst = 1'b1;
      cyc(2);
      n_checks++;
      if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b, expected 0", req_ready); else n_pass++;
      n_checks++;
      if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b, expected 1", pll_rst); else n_pass++;
      n_checks++;
      if ({den, dwe, daddr, di} !== 23'd0)
         $display("FAIL reset_drp: got den=%b dwe=%b addr=%h di=%h, expected all 0", den, dwe, daddr, di);
      else n_pass++;
      n_checks++;
      if ({clk_ready, done, err} !== 3'b000)
         $display("FAIL reset_status: got rdy=%b done=%b err=%b, expected 000", clk_ready, done, err);
      else n_pass++;
      rst = 1'b0;
      cyc(1);
      n_checks++;
      if (pll_rst !== 1'b0) $display("FAIL boot_pll_rst: got %b, expected 0", pll_rst); else n_pass++;
      lock_en = 1'b1;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (pll_locked) begin to = 1'b0; break; end
         @(negedge clk);
      end
      n_checks++;
      if (to) $display("FAIL boot_lock_wait: got timeout, expected PLL lock"); else n_pass++;
      // first sampling edge of LOCKED is the next rising edge; CLK_READY follows two edges later
      cyc(2);
      n_checks++;
      if (clk_ready !== 1'b0) $display("FAIL boot_ready_early: got %b, expected 0", clk_ready); else n_pass++;
      cyc(1);
      n_checks++;
      if ({clk_ready, req_ready} !== 2'b11)
         $display("FAIL boot_ready: got rdy=%b req_ready=%b, expected 11", clk_ready, req_ready);
      else n_pass++;
   endtask

   task automatic test_reconfig(input logic [5:0] m, input logic [5:0] d,
                                input logic [15:0] fb_di, input logic [15:0] co_di, input int lat);
      bit to, gd, ge;
      int d0;
      drp_lat = lat;
      d0 = n_done;
      exp_wr_q.push_back({5'h14, fb_di});
      exp_wr_q.push_back({5'h08, co_di});
      exp_ev_q.push_back(1'b1);
      send_req(m, d, to);
      n_checks++;
      if (to) $display("FAIL req_accept m=%0d d=%0d: got timeout, expected handshake", m, d); else n_pass++;
      wait_event(600, gd, ge, to);
      n_checks++;
      if ({to, gd, ge} !== 3'b010)
         $display("FAIL reconfig m=%0d d=%0d: got to=%b done=%b err=%b, expected done", m, d, to, gd, ge);
      else n_pass++;
      n_checks++;
      if (clk_ready !== 1'b1) $display("FAIL ready_after_done: got %b, expected 1", clk_ready); else n_pass++;
      cyc(5);
      n_checks++;
      if (n_done - d0 !== 1) $display("FAIL done_count: got %0d, expected 1", n_done - d0); else n_pass++;
      n_checks++;
      if (exp_wr_q.size() !== 0) $display("FAIL writes_pending: got %0d, expected 0", exp_wr_q.size()); else n_pass++;
      drp_lat = 1;
   endtask

   task automatic test_illegal;
      logic [5:0] ms [4] = '{6'd4, 6'd33, 6'd0, 6'd4};
      logic [5:0] ds [4] = '{6'd1, 6'd4, 6'd4, 6'd33};
      bit to, saw_rst;
      int e0, den0;
      for (int k = 0; k < 4; k++) begin
         e0 = n_err;
         den0 = n_den;
         saw_rst = 1'b0;
         exp_ev_q.push_back(1'b0);
         send_req(ms[k], ds[k], to);
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pll_rst) saw_rst = 1'b1;
         end
         n_checks++;
         if (to || (n_err - e0 !== 1))
            $display("FAIL illegal_err m=%0d d=%0d: got to=%b errs=%0d, expected 1 err", ms[k], ds[k], to, n_err - e0);
         else n_pass++;
         n_checks++;
         if (n_den !== den0) $display("FAIL illegal_den m=%0d d=%0d: got %0d DEN, expected 0", ms[k], ds[k], n_den - den0);
         else n_pass++;
         n_checks++;
         if (saw_rst !== 1'b0) $display("FAIL illegal_pll_rst m=%0d d=%0d: got 1, expected 0", ms[k], ds[k]);
         else n_pass++;
      end
   endtask

   task automatic test_drdy_timeout;
      bit to;
      int n, d0;
      d0 = n_done;
      drdy_en = 1'b0;
      exp_wr_q.push_back({5'h14, exp_di(6)});
      exp_ev_q.push_back(1'b0);
      send_req(6'd6, 6'd4, to);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (den) break;
      end
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (err) break;
      end
      n_checks++;
      if (n !== DRDY_TO) $display("FAIL drdy_timeout_cycles: got %0d, expected %0d", n, DRDY_TO); else n_pass++;
      n_checks++;
      if (pll_rst !== 1'b0) $display("FAIL drdy_timeout_pll_rst: got %b, expected 0", pll_rst); else n_pass++;
      drdy_en = 1'b1;
      wait_ready(500, to);
      n_checks++;
      if (to || (n_done !== d0))
         $display("FAIL drdy_timeout_recover: got to=%b dones=%0d, expected relock and 0 dones", to, n_done - d0);
      else n_pass++;
   endtask

   task automatic test_lock_timeout;
      bit to, gd, ge;
      lock_en = 1'b0;
      exp_wr_q.push_back({5'h14, exp_di(8)});
      exp_wr_q.push_back({5'h08, exp_di(8)});
      exp_ev_q.push_back(1'b0);
      send_req(6'd8, 6'd8, to);
      wait_event(LOCK_TO + 200, gd, ge, to);
      n_checks++;
      if ({to, gd, ge} !== 3'b001)
         $display("FAIL lock_timeout: got to=%b done=%b err=%b, expected err", to, gd, ge);
      else n_pass++;
      n_checks++;
      if ({clk_ready, req_ready} !== 2'b01)
         $display("FAIL lock_timeout_state: got rdy=%b req_ready=%b, expected 01", clk_ready, req_ready);
      else n_pass++;
      lock_en = 1'b1;
      wait_ready(200, to);
      n_checks++;
      if (to) $display("FAIL lock_timeout_relock: got timeout, expected CLK_READY"); else n_pass++;
   endtask

   task automatic test_lock_drop;
      bit to;
      int e0, d0;
      e0 = n_err;
      d0 = n_done;
      lock_en = 1'b0;
      cyc(5);
      n_checks++;
      if ({clk_ready, req_ready} !== 2'b01)
         $display("FAIL lock_drop: got rdy=%b req_ready=%b, expected 01", clk_ready, req_ready);
      else n_pass++;
      n_checks++;
      if ((n_err !== e0) || (n_done !== d0)) $display("FAIL lock_drop_events: got err/done pulses, expected none");
      else n_pass++;
      lock_en = 1'b1;
      wait_ready(200, to);
      n_checks++;
      if (to) $display("FAIL lock_drop_relock: got timeout, expected CLK_READY"); else n_pass++;
   endtask

   task automatic test_rst_mid;
      bit to, found;
      int e0, d0;
      e0 = n_err;
      d0 = n_done;
      drp_lat = 30;
      exp_wr_q.push_back({5'h14, exp_di(6)});
      exp_wr_q.push_back({5'h08, exp_di(5)});
      send_req(6'd6, 6'd5, to);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (den && dwe && (daddr == 5'h08)) begin found = 1'b1; break; end
      end
      n_checks++;
      if (!found) $display("FAIL rst_mid_co_write: got none, expected CO write"); else n_pass++;
      cyc(3);
      rst = 1'b1;
      cyc(1);
      n_checks++;
      if ({den, req_ready, pll_rst} !== 3'b001)
         $display("FAIL rst_mid_outputs: got den=%b req_ready=%b pll_rst=%b, expected 001", den, req_ready, pll_rst);
      else n_pass++;
      rst = 1'b0;
      drp_lat = 1;
      wait_ready(200, to);
      n_checks++;
      if (to) $display("FAIL rst_mid_relock: got timeout, expected CLK_READY"); else n_pass++;
      n_checks++;
      if ((n_err !== e0) || (n_done !== d0))
         $display("FAIL rst_mid_events: got err=%0d done=%0d, expected 0 0", n_err - e0, n_done - d0);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      bit to1, to2;
      int d0, e0;
      d0 = n_done;
      e0 = n_err;
      drp_lat = 2;
      exp_wr_q.push_back({5'h14, 16'h0202});
      exp_wr_q.push_back({5'h08, 16'h0101});
      exp_wr_q.push_back({5'h14, 16'h0243});
      exp_wr_q.push_back({5'h08, 16'h0142});
      exp_ev_q.push_back(1'b1);
      exp_ev_q.push_back(1'b1);
      send_req(6'd4, 6'd2, to1);
      send_req(6'd5, 6'd3, to2);
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (n_done - d0 >= 2) break;
      end
      cyc(3);
      n_checks++;
      if (to1 || to2 || (n_done - d0 !== 2) || (n_err !== e0))
         $display("FAIL back_to_back: got to=%b%b dones=%0d errs=%0d, expected 2 dones 0 errs",
                  to1, to2, n_done - d0, n_err - e0);
      else n_pass++;
      n_checks++;
      if (exp_wr_q.size() !== 0) $display("FAIL b2b_writes_pending: got %0d, expected 0", exp_wr_q.size()); else n_pass++;
      drp_lat = 1;
   endtask

`ifdef PLL_DRP_READBACK_EN
   task automatic test_readback_mismatch;
      bit to, gd, ge;
      int d0;
      d0 = n_done;
      rb_corrupt = 1'b1;
      exp_wr_q.push_back({5'h14, 16'h0202});
      exp_ev_q.push_back(1'b0);
      send_req(6'd4, 6'd2, to);
      wait_event(300, gd, ge, to);
      n_checks++;
      if ({to, gd, ge} !== 3'b001)
         $display("FAIL readback_mismatch: got to=%b done=%b err=%b, expected err", to, gd, ge);
      else n_pass++;
      rb_corrupt = 1'b0;
      wait_ready(300, to);
      n_checks++;
      if (to || (n_done !== d0)) $display("FAIL readback_recover: got to=%b dones=%0d, expected relock, 0 dones", to, n_done - d0);
      else n_pass++;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) drp_mem[i] = 16'h0000;
      test_reset();
      test_reconfig(6'd4, 6'd2, 16'h0202, 16'h0101, 1);
      test_reconfig(6'd5, 6'd3, 16'h0243, 16'h0142, 5);
      test_reconfig(6'd1, 6'd32, 16'h00C1, 16'h1010, 3);
      test_reconfig(6'd32, 6'd2, exp_di(32), exp_di(2), 1);
      test_illegal();
      test_drdy_timeout();
      test_lock_timeout();
      test_lock_drop();
      test_rst_mid();
      test_back_to_back();
`ifdef PLL_DRP_READBACK_EN
      test_readback_mismatch();
`endif
      cyc(5);
      n_checks++;
      if ((exp_ev_q.size() !== 0) || (exp_wr_q.size() !== 0))
         $display("FAIL scoreboard_drain: got ev=%0d wr=%0d left, expected 0 0", exp_ev_q.size(), exp_wr_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
